// File: rtl/bist_sig_analyzer.sv
// bist_sig_analyzer: 16-bit serial-input signature register compacting NUM_PAT valid z samples per run.
// Define GOLDEN_CMP_EN to build the registered golden-signature comparator that drives pass.
module bist_sig_analyzer #(
    parameter int          NUM_PAT = 4,
    parameter int          CNT_W   = 8,
    parameter logic [15:0] POLY    = 16'h1021,
    parameter logic [15:0] SEED    = 16'hFFFF,
    parameter logic [15:0] GOLDEN  = 16'h0000
) (
    input  logic        CP,
    input  logic        RST,
    input  logic        start,
    input  logic        z,
    input  logic        z_valid,
    output logic        busy,
    output logic        done,
    output logic [15:0] signature,
    output logic        pass
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_PAT - 1);
    state_t           state, state_nx;
    logic [15:0]      sig, sig_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic             fb;
    always_comb begin
        state_nx = state;
        sig_nx   = sig;
        cnt_nx   = cnt;
        fb       = sig[15] ^ z;
        case (state)
            IDLE, DONE: if (start) begin
                state_nx = RUN;
                sig_nx   = SEED;
                cnt_nx   = '0;
            end
            RUN: if (z_valid) begin
                sig_nx   = {sig[14:0], 1'b0} ^ (fb ? POLY : 16'h0000);
                cnt_nx   = cnt + 1'b1;
                state_nx = (cnt == LAST) ? DONE : RUN;
            end
            default: state_nx = IDLE;
        endcase
    end
    always_ff @(posedge CP) begin
        if (RST) begin
            state <= IDLE;
            sig   <= SEED;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            sig   <= sig_nx;
            cnt   <= cnt_nx;
        end
    end
    assign busy      = (state == RUN);
    assign done      = (state == DONE);
    assign signature = sig;
`ifdef GOLDEN_CMP_EN
    logic pass_q;
    // Judged once on entry to DONE, held while there, dropped on leaving.
    always_ff @(posedge CP) begin
        if (RST) pass_q <= 1'b0;
        else     pass_q <= (state_nx == DONE) && ((state == DONE) ? pass_q : (sig_nx == GOLDEN));
    end
    assign pass = pass_q;
`else
    logic unused_golden;
    assign unused_golden = ^GOLDEN;
    assign pass = 1'b0;
`endif
endmodule

// File: tb/tb_bist_sig_analyzer.sv
// tb_bist_sig_analyzer: three differently-parameterised analyzers on shared stimulus, checked against a bit-queue model.
module tb_bist_sig_analyzer;
    logic        CP = 1'b0, RST = 1'b1, start = 1'b0, z = 1'b0, z_valid = 1'b0;
    logic [2:0]  busy, done, pass;
    logic [15:0] sig [3];
    int          total = 0, bad = 0;
    bit          m_run [3];
    bit          m_done [3];
    bit          mq [3][$];

    always #5 CP = ~CP;

    bist_sig_analyzer u0 (
        .CP(CP), .RST(RST), .start(start), .z(z), .z_valid(z_valid),
        .busy(busy[0]), .done(done[0]), .signature(sig[0]), .pass(pass[0]));
    bist_sig_analyzer #(.NUM_PAT(1)) u1 (
        .CP(CP), .RST(RST), .start(start), .z(z), .z_valid(z_valid),
        .busy(busy[1]), .done(done[1]), .signature(sig[1]), .pass(pass[1]));
    bist_sig_analyzer #(.NUM_PAT(2), .SEED(16'h0000), .GOLDEN(16'h2042)) u2 (
        .CP(CP), .RST(RST), .start(start), .z(z), .z_valid(z_valid),
        .busy(busy[2]), .done(done[2]), .signature(sig[2]), .pass(pass[2]));

    function automatic int np_of(int i);
        return (i == 0) ? 4 : (i == 1) ? 1 : 2;
    endfunction
    function automatic logic [15:0] seed_of(int i);
        return (i == 2) ? 16'h0000 : 16'hFFFF;
    endfunction
    function automatic logic [15:0] golden_of(int i);
        return (i == 2) ? 16'h2042 : 16'h0000;
    endfunction

    // Signature as polynomial division of the collected bit stream by x^16+x^12+x^5+1.
    function automatic logic [15:0] sisr(logic [15:0] s0, int i);
        logic [15:0] s = s0;
        foreach (mq[i][k]) s = {s[14:0], 1'b0} ^ ((s[15] ^ mq[i][k]) ? 16'h1021 : 16'h0000);
        return s;
    endfunction

    task automatic chk(input string n, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", n, act, exp);
        end
    endtask

    always @(posedge CP) begin
        logic [15:0] e;
        logic        ep;
        for (int i = 0; i < 3; i++) begin
            if (RST) begin
                m_run[i] = 0; m_done[i] = 0; mq[i].delete();
            end else if (!m_run[i] && start) begin
                m_run[i] = 1; m_done[i] = 0; mq[i].delete();
            end else if (m_run[i] && z_valid) begin
                mq[i].push_back(z);
                if (mq[i].size() == np_of(i)) begin m_run[i] = 0; m_done[i] = 1; end
            end
        end
        #1;
        for (int i = 0; i < 3; i++) begin
            e = sisr(seed_of(i), i);
`ifdef GOLDEN_CMP_EN
            ep = m_done[i] && (e == golden_of(i));
`else
            ep = 1'b0;
`endif
            chk($sformatf("u%0d_busy", i), 16'(busy[i]), 16'(m_run[i]));
            chk($sformatf("u%0d_done", i), 16'(done[i]), 16'(m_done[i]));
            chk($sformatf("u%0d_sig", i), sig[i], e);
            chk($sformatf("u%0d_pass", i), 16'(pass[i]), 16'(ep));
        end
    end

    task automatic step(input logic s, input logic zz, input logic v, input logic r);
        start = s; z = zz; z_valid = v; RST = r;
        @(posedge CP);
        #2;
    endtask

    initial begin
        step(1, 1, 1, 1);
        step(1, 1, 1, 1);
        chk("rst_busy", 16'(busy[0]), 16'h0);
        chk("rst_done", 16'(done[0]), 16'h0);
        chk("rst_pass", 16'(pass[0]), 16'h0);
        chk("rst_sig", sig[0], 16'hFFFF);
        chk("rst_sig_u2", sig[2], 16'h0000);
        step(1, 0, 0, 0);
        chk("start_busy", 16'(busy[2]), 16'h1);
        step(0, 1, 1, 0);
        chk("two_bit_first", sig[2], 16'h1021);
        chk("one_bit_z1_sig", sig[1], 16'hFFFE);
        chk("one_bit_done", 16'(done[1]), 16'h1);
        chk("one_bit_busy", 16'(busy[1]), 16'h0);
        repeat (3) step(0, 0, 0, 0);
        chk("stall_busy", 16'(busy[2]), 16'h1);
        chk("stall_done", 16'(done[2]), 16'h0);
        step(0, 0, 1, 0);
        chk("two_bit_sig", sig[2], 16'h2042);
        chk("two_bit_done", 16'(done[2]), 16'h1);
`ifdef GOLDEN_CMP_EN
        chk("two_bit_pass", 16'(pass[2]), 16'h1);
`else
        chk("two_bit_pass", 16'(pass[2]), 16'h0);
`endif
        step(0, 0, 0, 1);
        chk("midrun_rst_sig", sig[0], 16'hFFFF);
        chk("midrun_rst_busy", 16'(busy[0]), 16'h0);
        step(1, 0, 0, 0);
        step(0, 0, 1, 0);
        chk("one_bit_z0_sig", sig[1], 16'hEFDF);
        chk("one_bit_z0_done", 16'(done[1]), 16'h1);
        step(1, 0, 1, 0);
        chk("restart_busy", 16'(busy[1]), 16'h1);
        chk("restart_sig", sig[1], 16'hFFFF);
        chk("zero_run_sig", sig[2], 16'h0000);
        step(0, 0, 1, 0);
        chk("restart_again_sig", sig[1], 16'hEFDF);
        chk("ignored_start_done", 16'(done[0]), 16'h0);
        chk("ignored_start_busy", 16'(busy[0]), 16'h1);
        step(0, 0, 1, 0);
        chk("four_zero_sig", sig[0], 16'h0E1F);
        chk("four_zero_done", 16'(done[0]), 16'h1);
        repeat (3000)
            step($urandom_range(0, 7) == 0, 1'($urandom_range(0, 1)),
                 $urandom_range(0, 3) != 0, $urandom_range(0, 60) == 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
